// File: rtl/pe_loopback_responder_if.sv
// NIC <-> PE-port handshake bundle. The NIC drives the master side, the
// loopback responder (router stand-in) drives the slave side.
interface pe_loopback_responder_if #(
  parameter int PACKET_WIDTH = 64
);
  logic                    pesi;
  logic [PACKET_WIDTH-1:0] pedi;
  logic                    peri;
  logic                    pero;
  logic                    peso;
  logic [PACKET_WIDTH-1:0] pedo;
  logic                    polarity_out;
  logic                    proto_err;

  modport master (
    output pesi, pedi, peri,
    input  pero, peso, pedo, polarity_out, proto_err
  );

  modport slave (
    input  pesi, pedi, peri,
    output pero, peso, pedo, polarity_out, proto_err
  );
endinterface

// File: rtl/pe_loopback_responder.sv
// Router-side PE port stand-in: buffers each NIC packet on its VC and returns
// it on the matching polarity. Optional PE_LOOPBACK_STAMP_EN stamps pedo[15:0].
module pe_loopback_responder #(
  parameter int PACKET_WIDTH = 64
) (
  input logic                    clk,
  input logic                    reset,
  pe_loopback_responder_if.slave pe
);
  localparam int VC_BIT = PACKET_WIDTH - 1;

  logic                    r_pol;
  logic                    r_peso;
  logic [PACKET_WIDTH-1:0] r_pedo;
  logic                    r_proto_err;

  logic [1:0]              w_vld;
  logic [PACKET_WIDTH-1:0] w_data [2];
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_launch;
  logic [PACKET_WIDTH-1:0] w_launch_data;
  logic [PACKET_WIDTH-1:0] w_pedo_next;

  // Accept targets buf[pol]; launch drains buf[~pol], so they never collide.
  assign pe.pero       = ~w_vld[r_pol];
  assign w_accept      = pe.pesi & pe.pero & (pe.pedi[VC_BIT] == r_pol);
  assign w_drop        = pe.pesi & ~w_accept;
  assign w_launch      = w_vld[~r_pol] & pe.peri;
  assign w_launch_data = w_data[~r_pol];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      localparam logic VC = 1'(gi);
      logic                    r_vld;
      logic [PACKET_WIDTH-1:0] r_data;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_vld <= 1'b0;
        end else if (w_accept && (r_pol == VC)) begin
          r_vld <= 1'b1;
        end else if (w_launch && (r_pol != VC)) begin
          r_vld <= 1'b0;
        end
      end

      // Payload needs no reset: it is only observed while r_vld is set.
      always_ff @(posedge clk) begin
        if (w_accept && (r_pol == VC)) begin
          r_data <= pe.pedi;
        end
      end

      assign w_vld[gi]  = r_vld;
      assign w_data[gi] = r_data;
    end
  endgenerate

`ifdef PE_LOOPBACK_STAMP_EN
  logic [15:0] r_seq;

  // One sequence number per launch, shared by both VCs, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq <= 16'h0000;
    end else if (w_launch) begin
      r_seq <= r_seq + 16'h0001;
    end
  end

  assign w_pedo_next = {w_launch_data[PACKET_WIDTH-1:16], r_seq};
`else
  assign w_pedo_next = w_launch_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pol       <= 1'b0;
      r_peso      <= 1'b0;
      r_pedo      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_pol  <= ~r_pol;
      r_peso <= w_launch;
      if (w_launch) begin
        r_pedo <= w_pedo_next;
      end
      if (w_drop) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign pe.peso         = r_peso;
  assign pe.pedo         = r_pedo;
  assign pe.polarity_out = r_pol;
  assign pe.proto_err    = r_proto_err;
endmodule

// File: tb/tb_pe_loopback_responder.sv
// Directed bench for pe_loopback_responder: reset, single return, alternating
// VCs, back-pressure, drops, mid-transfer reset and (with the macro) stamp wrap.
module tb_pe_loopback_responder;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   cnt;

  pe_loopback_responder_if #(.PACKET_WIDTH(64)) pe_if ();

  pe_loopback_responder #(.PACKET_WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .pe    (pe_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected returned data: with stamping, low 16 bits carry the launch index.
  function automatic logic [63:0] ret(input logic [63:0] d, input int idx);
`ifdef PE_LOOPBACK_STAMP_EN
    return {d[63:16], 16'(idx)};
`else
    return d;
`endif
  endfunction

  // Alternating stream starts on a pol=1 cycle: even steps VC1, odd steps VC0.
  function automatic logic [63:0] alt_pkt(input int c);
    if (c % 2 == 0) return 64'h8000_0000_0000_0200 + 64'(c);
    return 64'h0000_0000_0000_0100 + 64'(c);
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    pe_if.pesi = 1'b0;
    pe_if.pedi = '0;
    pe_if.peri = 1'b1;
    tick();
    tick();
    chk("rst_pol", pe_if.polarity_out, 1'b0);
    chk("rst_pero", pe_if.pero, 1'b1);
    chk("rst_peso", pe_if.peso, 1'b0);
    chk("rst_pedo", pe_if.pedo, 64'h0);
    chk("rst_err", pe_if.proto_err, 1'b0);
    reset = 1'b0;

    // Single VC0 packet on the first pol=0 cycle.
    pe_if.pesi = 1'b1;
    pe_if.pedi = 64'h0000_0000_0000_00AA;
    tick();
    pe_if.pesi = 1'b0;
    chk("aa_pol1", pe_if.polarity_out, 1'b1);
    chk("aa_peso_t1", pe_if.peso, 1'b0);
    tick();
    chk("aa_peso_t2", pe_if.peso, 1'b1);
    chk("aa_pedo", pe_if.pedo, ret(64'h0000_0000_0000_00AA, 0));
    chk("aa_pol0", pe_if.polarity_out, 1'b0);
    chk("aa_err", pe_if.proto_err, 1'b0);
    tick();
    chk("aa_peso_t3", pe_if.peso, 1'b0);
    chk("aa_pedo_hold", pe_if.pedo, ret(64'h0000_0000_0000_00AA, 0));

    // Alternating VCs every cycle, full combined throughput.
    for (int c = 0; c < 8; c++) begin
      chk("alt_pol", pe_if.polarity_out, (c % 2 == 0) ? 1'b1 : 1'b0);
      chk("alt_pero", pe_if.pero, 1'b1);
      if (c >= 2) begin
        chk("alt_peso", pe_if.peso, 1'b1);
        chk("alt_pedo", pe_if.pedo, ret(alt_pkt(c - 2), c - 1));
      end else begin
        chk("alt_peso_idle", pe_if.peso, 1'b0);
      end
      pe_if.pesi = (c < 6);
      pe_if.pedi = (c < 6) ? alt_pkt(c) : 64'h0;
      tick();
    end
    chk("alt_drain_peso", pe_if.peso, 1'b0);
    chk("alt_err", pe_if.proto_err, 1'b0);

    // Back-pressure: VC0 packet held while peri=0.
    tick();
    pe_if.peri = 1'b0;
    pe_if.pesi = 1'b1;
    pe_if.pedi = 64'h0000_0000_0000_0055;
    tick();
    pe_if.pesi = 1'b0;
    for (int u = 1; u <= 7; u++) begin
      chk("bp_peso", pe_if.peso, 1'b0);
      chk("bp_pero", pe_if.pero, (u % 2 == 1) ? 1'b1 : 1'b0);
      if (u == 7) pe_if.peri = 1'b1;
      tick();
    end
    chk("bp_ret_peso", pe_if.peso, 1'b1);
    chk("bp_ret_pedo", pe_if.pedo, ret(64'h0000_0000_0000_0055, 7));
    chk("bp_ret_pol", pe_if.polarity_out, 1'b0);
    chk("bp_ret_pero", pe_if.pero, 1'b1);
    tick();
    chk("bp_after_peso", pe_if.peso, 1'b0);

    // Fill VC1, overflow it (drop), then reset with the buffer full.
    pe_if.peri = 1'b0;
    pe_if.pesi = 1'b1;
    pe_if.pedi = 64'h8000_0000_0000_0077;
    tick();
    pe_if.pesi = 1'b0;
    chk("full_err0", pe_if.proto_err, 1'b0);
    tick();
    chk("full_pero", pe_if.pero, 1'b0);
    pe_if.pesi = 1'b1;
    pe_if.pedi = 64'h8000_0000_0000_0078;
    tick();
    pe_if.pesi = 1'b0;
    chk("full_drop_err", pe_if.proto_err, 1'b1);
    chk("full_peso", pe_if.peso, 1'b0);
    reset = 1'b1;
    pe_if.peri = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_pol", pe_if.polarity_out, 1'b0);
    chk("mrst_peso", pe_if.peso, 1'b0);
    chk("mrst_pedo", pe_if.pedo, 64'h0);
    chk("mrst_err", pe_if.proto_err, 1'b0);
    chk("mrst_pero", pe_if.pero, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mrst_no_ret", pe_if.peso, 1'b0);
      if (k == 0) chk("mrst_pero_vc1", pe_if.pero, 1'b1);
    end

    // Wrong-VC send on a pol=0 cycle.
    pe_if.pesi = 1'b1;
    pe_if.pedi = 64'h8000_0000_0000_00EE;
    tick();
    pe_if.pesi = 1'b0;
    chk("vc_err", pe_if.proto_err, 1'b1);
    chk("vc_pero", pe_if.pero, 1'b1);
    tick();
    chk("vc_peso_a", pe_if.peso, 1'b0);
    chk("vc_err_sticky", pe_if.proto_err, 1'b1);
    tick();
    chk("vc_peso_b", pe_if.peso, 1'b0);

`ifdef PE_LOOPBACK_STAMP_EN
    // 65537 launches: the last two carry stamps 0xFFFF then 0x0000.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 65545; c++) begin
      if (pe_if.peso === 1'b1) begin
        cnt++;
        if (cnt == 65536) chk("stamp_ffff", 64'(pe_if.pedo[15:0]), 64'h0000_0000_0000_FFFF);
        if (cnt == 65537) chk("stamp_wrap", 64'(pe_if.pedo[15:0]), 64'h0);
      end
      pe_if.pesi = (c < 65537);
      pe_if.pedi = (c % 2 == 1) ? 64'h8000_0000_0000_0000 : 64'h0;
      tick();
    end
    pe_if.pesi = 1'b0;
    chk("stamp_count", 64'(cnt), 64'd65537);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
